// File: rtl/dac_spi_tx.sv
// dac_spi_tx: sends two 32-bit command frames (channel A, then channel B) to a
// serial DAC, with a chip-select gap between frames and a one-cycle done pulse.
module dac_spi_tx #(
    parameter int         HALF_PER = 2,
    parameter logic [3:0] CMD      = 4'b0011
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       GO_DAC,
    input  logic [7:0] DAC0,
    input  logic [7:0] DAC1,
    output logic       DONE_DAC,
    output logic       DAC_CS,
    output logic       SPI_MOSI,
    output logic       SPI_CLK_DAC,
    output logic       DAC_CLR
);
    typedef enum logic [2:0] {IDLE, FRAME0, GAP, FRAME1, DONE} state_t;
    localparam logic [8:0] HP_M1  = 9'(HALF_PER - 1);
    localparam logic [8:0] GAP_M1 = 9'(2 * HALF_PER - 1);
    state_t      state, nxt;
    logic [8:0]  div;
    logic        half;
    logic [4:0]  bits;
    logic [31:0] sh;
    logic [7:0]  code1;
    logic        clr;
    logic        in_frame, bit_end, frame_end, gap_end, start;
    assign in_frame  = (state == FRAME0) || (state == FRAME1);
    assign bit_end   = in_frame && half && (div == HP_M1);
    assign frame_end = bit_end && (bits == 5'd31);
    assign gap_end   = (state == GAP) && (div == GAP_M1);
    // clr doubles as the post-reset arm flag, so GO is first honoured on the second edge
    assign start     = (state == IDLE) && GO_DAC && clr;
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= nxt;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = FRAME0;
            FRAME0:  if (frame_end) nxt = GAP;
            GAP:     if (gap_end) nxt = FRAME1;
            FRAME1:  if (frame_end) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div   <= '0;
            half  <= 1'b0;
            bits  <= '0;
            sh    <= '0;
            code1 <= '0;
            clr   <= 1'b0;
        end else begin
            clr <= 1'b1;
            if (start) begin
                sh    <= {8'h00, CMD, 4'h0, DAC0, 8'h00};
                code1 <= DAC1;
                div   <= '0;
                half  <= 1'b0;
                bits  <= '0;
            end else if (gap_end) begin
                sh  <= {8'h00, CMD, 4'h1, code1, 8'h00};
                div <= '0;
            end else if (in_frame) begin
                div <= (div == HP_M1) ? '0 : div + 9'd1;
                if (div == HP_M1) half <= ~half;
                // shifting at the end of the high phase keeps MOSI changes in the low phase
                if (bit_end) begin
                    sh   <= {sh[30:0], 1'b0};
                    bits <= bits + 5'd1;
                end
            end else if (state == GAP) begin
                div <= div + 9'd1;
            end else begin
                div  <= '0;
                half <= 1'b0;
                bits <= '0;
            end
        end
    end
    always_comb begin
        DAC_CS      = !in_frame;
        SPI_CLK_DAC = in_frame && half;
        SPI_MOSI    = in_frame && sh[31];
        DONE_DAC    = (state == DONE);
        DAC_CLR     = clr;
    end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: checks dac_spi_tx at HALF_PER=2 and HALF_PER=1 against a frame-level
// model of the two DAC command words, the SPI waveform rules and the reset behaviour.
module tb_dac_spi_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] go = 2'b00;
    logic [7:0] d0 [2];
    logic [7:0] d1 [2];
    logic [1:0] done, cs, mosi, sclk, clr;
    int ntest = 0, nfail = 0, cyc = 0;
    int hp [2] = '{2, 1};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    dac_spi_tx #(.HALF_PER(2)) u0 (.clk(clk), .reset(reset), .GO_DAC(go[0]), .DAC0(d0[0]), .DAC1(d1[0]),
        .DONE_DAC(done[0]), .DAC_CS(cs[0]), .SPI_MOSI(mosi[0]), .SPI_CLK_DAC(sclk[0]), .DAC_CLR(clr[0]));
    dac_spi_tx #(.HALF_PER(1)) u1 (.clk(clk), .reset(reset), .GO_DAC(go[1]), .DAC0(d0[1]), .DAC1(d1[1]),
        .DONE_DAC(done[1]), .DAC_CS(cs[1]), .SPI_MOSI(mosi[1]), .SPI_CLK_DAC(sclk[1]), .DAC_CLR(clr[1]));

    // Waveform observer: decodes frames from the SPI pins and tallies rule violations
    logic [31:0] fq0 [$];
    logic [31:0] fq1 [$];
    logic [31:0] word [2];
    int cs_cnt [2], edges [2], age [2], since_rise [2], hi_cnt [2], gap [2], nfr [2], viol [2], dcount [2];
    logic [1:0] prev_cs = 2'b11, prev_sclk = 2'b00, prev_mosi = 2'b00;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset) begin
                cs_cnt[i] = 0; edges[i] = 0; age[i] = 0; since_rise[i] = 1000; hi_cnt[i] = 0; nfr[i] = 0;
                word[i] = '0; prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
                if (i == 0) fq0.delete(); else fq1.delete();
            end else begin
                if (cs[i]) begin
                    if (sclk[i] || mosi[i]) viol[i]++;
                    if (!prev_cs[i]) begin
                        if (cs_cnt[i] != 64 * hp[i] || edges[i] != 32) viol[i]++;
                        if (i == 0) fq0.push_back(word[i]); else fq1.push_back(word[i]);
                        nfr[i]++;
                        hi_cnt[i] = 0;
                    end
                    hi_cnt[i]++;
                end else begin
                    if (prev_cs[i]) begin
                        if (nfr[i] == 1) gap[i] = hi_cnt[i];
                        cs_cnt[i] = 0; edges[i] = 0; word[i] = '0;
                    end else if (mosi[i] != prev_mosi[i] && (sclk[i] || since_rise[i] < hp[i])) viol[i]++;
                    cs_cnt[i]++;
                    if (sclk[i] && !prev_sclk[i]) begin
                        edges[i]++;
                        word[i] = {word[i][30:0], mosi[i]};
                        if (age[i] < hp[i]) viol[i]++;
                        since_rise[i] = 0;
                    end
                end
                age[i] = (mosi[i] != prev_mosi[i]) ? 1 : age[i] + 1;
                since_rise[i]++;
                if (done[i]) dcount[i]++;
                prev_cs[i] = cs[i]; prev_sclk[i] = sclk[i]; prev_mosi[i] = mosi[i];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        ntest++;
        assert (obs === expv) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] exp_frame(input logic [3:0] addr, input logic [7:0] code);
        return 32'h0030_0000 + ({28'h0, addr} << 16) + ({24'h0, code} << 8);
    endfunction

    function automatic logic [31:0] pop(input int i);
        logic [31:0] v = 'x;
        if (i == 0) begin
            if (fq0.size() > 0) v = fq0.pop_front();
        end else if (fq1.size() > 0) v = fq1.pop_front();
        return v;
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? fq0.size() : fq1.size();
    endfunction

    task automatic launch(input int i, input logic [7:0] a, input logic [7:0] b, output int t0, output int dc0);
        d0[i] = a; d1[i] = b; gap[i] = -1; nfr[i] = 0; dc0 = dcount[i];
        @(posedge clk); #1 go[i] = 1'b1; t0 = cyc;
        @(posedge clk); #1 go[i] = 1'b0;
        d0[i] = 8'($urandom); d1[i] = 8'($urandom);
    endtask

    task automatic finish(input int i, input int t0, input int dc0, input logic [7:0] a, input logic [7:0] b,
                          input bit poke);
        int n = 0;
        if (poke) begin
            repeat (40) @(posedge clk);
            #1 go[i] = 1'b1; d0[i] = 8'hFF;
            @(posedge clk); #1 go[i] = 1'b0;
        end
        while (!done[i] && n < 3000) begin
            @(negedge clk); #1;
            n++;
        end
        chk("done_seen", 32'(done[i]), 32'd1);
        chk("latency", 32'(cyc - t0), 32'(1 + 130 * hp[i]));
        if (poke) begin
            go[i] = 1'b1;
            @(posedge clk); #1 go[i] = 1'b0;
        end
        chk("frame_count", 32'(qsize(i)), 32'd2);
        chk("frame0", pop(i), exp_frame(4'h0, a));
        chk("frame1", pop(i), exp_frame(4'h1, b));
        chk("gap_len", 32'(gap[i]), 32'(2 * hp[i]));
        chk("spi_rules", 32'(viol[i]), 32'd0);
        chk("done_pulses", 32'(dcount[i] - dc0), 32'd1);
    endtask

    task automatic xfer(input int i, input logic [7:0] a, input logic [7:0] b, input bit poke);
        int t0, dc0;
        launch(i, a, b, t0, dc0);
        finish(i, t0, dc0, a, b, poke);
    endtask

    initial begin
        int t0, dc0, dc1;
        d0[0] = '0; d1[0] = '0; d0[1] = '0; d1[1] = '0;
        #2;
        chk("rst_cs", 32'(cs), 32'h3);
        chk("rst_sclk", 32'(sclk), 32'h0);
        chk("rst_mosi", 32'(mosi), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_clr", 32'(clr), 32'h0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk("clr_release", 32'(clr), 32'h3);

        xfer(0, 8'hA5, 8'h3C, 1'b0);
        xfer(0, 8'hA5, 8'h3C, 1'b1);
        dc1 = dcount[0];
        repeat (300) @(posedge clk);
        #1;
        chk("busy_no_extra_frames", 32'(qsize(0)), 32'd0);
        chk("busy_no_extra_done", 32'(dcount[0] - dc1), 32'd0);
        chk("busy_cs_idle", 32'(cs[0]), 32'd1);
        xfer(0, 8'h00, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) xfer(0, 8'($urandom), 8'($urandom), 1'b0);

        xfer(1, 8'hA5, 8'h3C, 1'b0);
        xfer(1, 8'h00, 8'hFF, 1'b0);
        for (int k = 0; k < 3; k++) xfer(1, 8'($urandom), 8'($urandom), 1'b0);

        launch(0, 8'h5A, 8'hC3, t0, dc0);
        while (cyc < t0 + 175) @(negedge clk);
        chk("pre_abort_pins", {29'h0, cs[0], sclk[0], mosi[0]}, 32'h3);
        #2 reset = 1'b0;
        #1;
        chk("abort_cs", 32'(cs), 32'h3);
        chk("abort_sclk", 32'(sclk), 32'h0);
        chk("abort_mosi", 32'(mosi), 32'h0);
        chk("abort_clr", 32'(clr), 32'h0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done), 32'h0);
        d0[0] = 8'h81; d1[0] = 8'h7E; gap[0] = -1; nfr[0] = 0;
        reset = 1'b1; go[0] = 1'b1;
        @(negedge clk);
        chk("clr_before_edge", 32'(clr), 32'h0);
        @(posedge clk); #1;
        chk("clr_after_edge", 32'(clr), 32'h3);
        chk("go_ignored_first_edge", 32'(cs[0]), 32'd1);
        @(posedge clk); #1 go[0] = 1'b0;
        chk("go_accepted_second_edge", 32'(cs[0]), 32'd0);
        t0 = cyc - 1;
        finish(0, t0, dc0, 8'h81, 8'h7E, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end
endmodule
